// File: rtl/dispatch_pkg.sv
// Shared configuration for the dispatch stage: widths, opcode codes and
// operand-tracking types.
package dispatch_pkg;

  localparam int unsigned NICK_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_W  = 5;

  // Code 0 is deliberately unused so a cleared entry decodes as nothing.
  typedef enum logic [OP_W-1:0] {
    OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL  = 6'd3,  OP_JALR  = 6'd4,
    OP_BEQ  = 6'd5,  OP_BNE   = 6'd6,  OP_BLT  = 6'd7,  OP_BGE   = 6'd8,
    OP_BLTU = 6'd9,  OP_BGEU  = 6'd10,
    OP_LB   = 6'd11, OP_LH    = 6'd12, OP_LW   = 6'd13, OP_LBU   = 6'd14,
    OP_LHU  = 6'd15, OP_SB    = 6'd16, OP_SH   = 6'd17, OP_SW    = 6'd18,
    OP_ADDI = 6'd19, OP_SLTI  = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22,
    OP_ORI  = 6'd23, OP_ANDI  = 6'd24, OP_SLLI = 6'd25, OP_SRLI  = 6'd26,
    OP_SRAI = 6'd27, OP_ADD   = 6'd28, OP_SUB  = 6'd29, OP_SLL   = 6'd30,
    OP_SLT  = 6'd31, OP_SLTU  = 6'd32, OP_XOR  = 6'd33, OP_SRL   = 6'd34,
    OP_SRA  = 6'd35, OP_OR    = 6'd36, OP_AND  = 6'd37
  } op_e;

  typedef enum logic {ST_EMPTY = 1'b0, ST_HELD = 1'b1} state_e;

  typedef struct packed {
    logic              en;
    logic [NICK_W-1:0] nick;
    logic [DATA_W-1:0] dt;
  } bcast_t;

  typedef struct packed {
    logic [NICK_W-1:0] nick;
    logic [DATA_W-1:0] dt;
  } opnd_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rd;
  } entry_t;

  function automatic logic is_ls(input logic [OP_W-1:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic no_rd(input logic [OP_W-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE,
                      OP_BLTU, OP_BGEU};
  endfunction

  // Resolve a pending operand against this cycle's broadcasts; EX beats SLB.
  function automatic opnd_t snoop(input opnd_t cur, input bcast_t ex,
                                  input bcast_t slb);
    opnd_t res;
    res = cur;
    if (cur.nick != '0) begin
      if (ex.en && ex.nick == cur.nick)        res = '{nick: '0, dt: ex.dt};
      else if (slb.en && slb.nick == cur.nick) res = '{nick: '0, dt: slb.dt};
    end
    return res;
  endfunction

endpackage

// File: rtl/dispatch_if.sv
// Bus bundle between the dispatch stage and IQ / regfile / ROB / RS / SLB.
interface dispatch_if;
  import dispatch_pkg::*;

  logic              iIQ_en;
  logic [OP_W-1:0]   iIQ_op;
  logic [ADDR_W-1:0] iIQ_pc;
  logic [DATA_W-1:0] iIQ_imm;
  logic [REG_W-1:0]  iIQ_rd, iIQ_rs1, iIQ_rs2;
  logic              oIQ_pop;

  logic [REG_W-1:0]  oREG_rs1, oREG_rs2;
  logic [NICK_W-1:0] iREG_rs1_nick, iREG_rs2_nick;
  logic [DATA_W-1:0] iREG_rs1_dt, iREG_rs2_dt;
  logic              oREG_rd_en;
  logic [REG_W-1:0]  oREG_rd;
  logic [NICK_W-1:0] oREG_rd_nick;

  logic              iROB_full;
  logic [NICK_W-1:0] iROB_nick;
  logic              oROB_en;
  logic [OP_W-1:0]   oROB_op;
  logic [ADDR_W-1:0] oROB_pc;
  logic [REG_W-1:0]  oROB_rd;

  logic              iRS_full, iSLB_full;

  logic              iEX_en, iSLB_en;
  logic [NICK_W-1:0] iEX_nick, iSLB_nick;
  logic [DATA_W-1:0] iEX_dt, iSLB_dt;

  logic              oDP_en, oDP_ls;
  logic [OP_W-1:0]   oDP_op;
  logic [ADDR_W-1:0] oDP_pc;
  logic [DATA_W-1:0] oDP_imm;
  logic [NICK_W-1:0] oDP_rd_nick, oDP_rs1_nick, oDP_rs2_nick;
  logic [DATA_W-1:0] oDP_rs1_dt, oDP_rs2_dt;

  modport master (
    input  iIQ_en, iIQ_op, iIQ_pc, iIQ_imm, iIQ_rd, iIQ_rs1, iIQ_rs2,
           iREG_rs1_nick, iREG_rs2_nick, iREG_rs1_dt, iREG_rs2_dt,
           iROB_full, iROB_nick, iRS_full, iSLB_full,
           iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt,
    output oIQ_pop, oREG_rs1, oREG_rs2, oREG_rd_en, oREG_rd, oREG_rd_nick,
           oROB_en, oROB_op, oROB_pc, oROB_rd,
           oDP_en, oDP_ls, oDP_op, oDP_pc, oDP_imm, oDP_rd_nick,
           oDP_rs1_nick, oDP_rs1_dt, oDP_rs2_nick, oDP_rs2_dt
  );

  modport slave (
    output iIQ_en, iIQ_op, iIQ_pc, iIQ_imm, iIQ_rd, iIQ_rs1, iIQ_rs2,
           iREG_rs1_nick, iREG_rs2_nick, iREG_rs1_dt, iREG_rs2_dt,
           iROB_full, iROB_nick, iRS_full, iSLB_full,
           iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt,
    input  oIQ_pop, oREG_rs1, oREG_rs2, oREG_rd_en, oREG_rd, oREG_rd_nick,
           oROB_en, oROB_op, oROB_pc, oROB_rd,
           oDP_en, oDP_ls, oDP_op, oDP_pc, oDP_imm, oDP_rd_nick,
           oDP_rs1_nick, oDP_rs1_dt, oDP_rs2_nick, oDP_rs2_dt
  );
endinterface

// File: rtl/dispatch_opnd.sv
// One source operand: capture with rename/broadcast bypass, snoop while held,
// and same-cycle broadcast bypass on the dispatch output.
module dispatch_opnd
  import dispatch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rdy,
  input  logic              i_clr,
  input  logic              i_pop,
  input  logic [REG_W-1:0]  i_rs,
  input  logic [NICK_W-1:0] i_reg_nick,
  input  logic [DATA_W-1:0] i_reg_dt,
  input  logic              i_fire_wr,
  input  logic [REG_W-1:0]  i_ent_rd,
  input  logic [NICK_W-1:0] i_rob_nick,
  input  bcast_t            i_ex,
  input  bcast_t            i_slb,
  output logic [NICK_W-1:0] o_nick,
  output logic [DATA_W-1:0] o_dt
);

  opnd_t r_opnd;
  opnd_t w_cap;
  opnd_t w_snp;

  // The regfile has not yet seen the rename written by the firing entry.
  always_comb begin
    w_cap = '0;
    if (i_rs == '0)                         w_cap = '0;
    else if (i_fire_wr && i_rs == i_ent_rd) w_cap = '{nick: i_rob_nick, dt: '0};
    else w_cap = snoop('{nick: i_reg_nick, dt: i_reg_dt}, i_ex, i_slb);
    w_snp = snoop(r_opnd, i_ex, i_slb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_opnd <= '0;
    else if (i_clr)  r_opnd <= '0;
    else if (i_rdy)  r_opnd <= i_pop ? w_cap : w_snp;
  end

  assign o_nick = w_snp.nick;
  assign o_dt   = w_snp.dt;

endmodule

// File: rtl/dispatch.sv
// Single-entry dispatch stage: takes the IQ head, renames its operands and
// hands it to ROB plus RS or SLB when the targets have room.
module dispatch #(
  parameter int unsigned NICK_W = dispatch_pkg::NICK_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           clr,
  dispatch_if.master     bus
);
  import dispatch_pkg::*;

  state_e            r_state, w_state_nx;
  entry_t            r_ent;
  logic              w_live, w_held, w_ls, w_stall, w_fire, w_pop, w_fire_wr;
  logic [NICK_W-1:0] w_rd_nick;
  bcast_t            w_ex, w_slb;

  assign w_ex  = '{en: bus.iEX_en,  nick: bus.iEX_nick,  dt: bus.iEX_dt};
  assign w_slb = '{en: bus.iSLB_en, nick: bus.iSLB_nick, dt: bus.iSLB_dt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_EMPTY;
    else      r_state <= w_state_nx;
  end

  // Handshake and next state; rst gating keeps outputs quiet during reset.
  always_comb begin
    w_state_nx = r_state;
    w_live     = rst && rdy && !clr;
    w_held     = (r_state == ST_HELD);
    w_ls       = is_ls(r_ent.op);
    w_stall    = w_held && (bus.iROB_full || (w_ls ? bus.iSLB_full : bus.iRS_full));
    w_fire     = w_live && w_held && !w_stall;
    w_pop      = w_live && bus.iIQ_en && (!w_held || w_fire);
    w_fire_wr  = w_fire && (r_ent.rd != '0) && !no_rd(r_ent.op);
    if (clr) begin
      w_state_nx = ST_EMPTY;
    end else if (rdy) begin
      case (r_state)
        ST_EMPTY: if (w_pop)            w_state_nx = ST_HELD;
        ST_HELD:  if (w_fire && !w_pop) w_state_nx = ST_EMPTY;
        default:                        w_state_nx = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_ent <= '0;
    else if (clr)   r_ent <= '0;
    else if (w_pop) r_ent <= '{op: bus.iIQ_op, pc: bus.iIQ_pc, imm: bus.iIQ_imm,
                               rd: bus.iIQ_rd};
  end

  dispatch_opnd u_rs1 (
    .clk, .rst_n(rst), .i_rdy(rdy), .i_clr(clr), .i_pop(w_pop),
    .i_rs(bus.iIQ_rs1), .i_reg_nick(bus.iREG_rs1_nick), .i_reg_dt(bus.iREG_rs1_dt),
    .i_fire_wr(w_fire_wr), .i_ent_rd(r_ent.rd), .i_rob_nick(bus.iROB_nick),
    .i_ex(w_ex), .i_slb(w_slb), .o_nick(bus.oDP_rs1_nick), .o_dt(bus.oDP_rs1_dt)
  );

  dispatch_opnd u_rs2 (
    .clk, .rst_n(rst), .i_rdy(rdy), .i_clr(clr), .i_pop(w_pop),
    .i_rs(bus.iIQ_rs2), .i_reg_nick(bus.iREG_rs2_nick), .i_reg_dt(bus.iREG_rs2_dt),
    .i_fire_wr(w_fire_wr), .i_ent_rd(r_ent.rd), .i_rob_nick(bus.iROB_nick),
    .i_ex(w_ex), .i_slb(w_slb), .o_nick(bus.oDP_rs2_nick), .o_dt(bus.oDP_rs2_dt)
  );

  assign w_rd_nick = w_fire ? bus.iROB_nick : '0;

  assign bus.oIQ_pop      = w_pop;
  assign bus.oREG_rs1     = rst ? bus.iIQ_rs1 : '0;
  assign bus.oREG_rs2     = rst ? bus.iIQ_rs2 : '0;
  assign bus.oREG_rd_en   = w_fire_wr;
  assign bus.oREG_rd      = r_ent.rd;
  assign bus.oREG_rd_nick = w_fire_wr ? bus.iROB_nick : '0;
  assign bus.oROB_en      = w_fire;
  assign bus.oROB_op      = r_ent.op;
  assign bus.oROB_pc      = r_ent.pc;
  assign bus.oROB_rd      = r_ent.rd;
  assign bus.oDP_en       = w_fire;
  assign bus.oDP_ls       = w_ls;
  assign bus.oDP_op       = r_ent.op;
  assign bus.oDP_pc       = r_ent.pc;
  assign bus.oDP_imm      = r_ent.imm;
  assign bus.oDP_rd_nick  = w_rd_nick;

endmodule

// File: tb/tb_dispatch.sv
// Directed bench for the dispatch stage with hand-computed expectations.
module tb_dispatch;
  import dispatch_pkg::*;

  logic clk, rst, rdy, clr;
  int   n_chk, n_fail;

  dispatch_if bus();

  dispatch u_dut (.clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_iq(input logic en, input logic [5:0] op, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    bus.iIQ_en = en; bus.iIQ_op = op; bus.iIQ_pc = pc; bus.iIQ_imm = imm;
    bus.iIQ_rd = rd; bus.iIQ_rs1 = rs1; bus.iIQ_rs2 = rs2;
  endtask

  task automatic set_reg(input logic [3:0] n1, input logic [31:0] d1,
                         input logic [3:0] n2, input logic [31:0] d2);
    bus.iREG_rs1_nick = n1; bus.iREG_rs1_dt = d1;
    bus.iREG_rs2_nick = n2; bus.iREG_rs2_dt = d2;
  endtask

  task automatic idle();
    set_iq(1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    set_reg(4'd0, 32'h0, 4'd0, 32'h0);
    bus.iROB_full = 1'b0; bus.iROB_nick = 4'd1;
    bus.iRS_full = 1'b0;  bus.iSLB_full = 1'b0;
    bus.iEX_en = 1'b0;  bus.iEX_nick = 4'd0;  bus.iEX_dt = 32'h0;
    bus.iSLB_en = 1'b0; bus.iSLB_nick = 4'd0; bus.iSLB_dt = 32'h0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0; rdy = 1'b1; clr = 1'b0;
    idle();
    set_iq(1'b1, OP_ADD, 32'h40, 32'h0, 5'd1, 5'd4, 5'd5);
    tick(); tick(); #1;
    chk("rst_pop",   32'(bus.oIQ_pop), 32'd0);
    chk("rst_dp_en", 32'(bus.oDP_en), 32'd0);
    chk("rst_rob_en", 32'(bus.oROB_en), 32'd0);
    chk("rst_reg_rs1", 32'(bus.oREG_rs1), 32'd0);
    chk("rst_dp_pc", bus.oDP_pc, 32'h0);
    rst = 1'b1; bus.iIQ_en = 1'b0;
    tick();

    // ADDI x1,x0,5 then ADD x2,x1,x1 back to back
    set_iq(1'b1, OP_ADDI, 32'h100, 32'd5, 5'd1, 5'd0, 5'd0);
    bus.iROB_nick = 4'd3; #1;
    chk("addi_pop", 32'(bus.oIQ_pop), 32'd1);
    chk("addi_nofire_empty", 32'(bus.oDP_en), 32'd0);
    tick();
    set_iq(1'b1, OP_ADD, 32'h104, 32'd0, 5'd2, 5'd1, 5'd1); #1;
    chk("addi_dp_en", 32'(bus.oDP_en), 32'd1);
    chk("addi_rob_en", 32'(bus.oROB_en), 32'd1);
    chk("addi_rd_nick", 32'(bus.oDP_rd_nick), 32'd3);
    chk("addi_rs1_nick", 32'(bus.oDP_rs1_nick), 32'd0);
    chk("addi_rs1_dt", bus.oDP_rs1_dt, 32'd0);
    chk("addi_reg_rd_en", 32'(bus.oREG_rd_en), 32'd1);
    chk("addi_reg_rd", 32'(bus.oREG_rd), 32'd1);
    chk("addi_reg_rd_nick", 32'(bus.oREG_rd_nick), 32'd3);
    chk("addi_imm", bus.oDP_imm, 32'd5);
    chk("add_pop_on_fire", 32'(bus.oIQ_pop), 32'd1);
    tick();
    bus.iIQ_en = 1'b0; bus.iROB_nick = 4'd4; #1;
    chk("add_dp_en", 32'(bus.oDP_en), 32'd1);
    chk("add_rd_nick", 32'(bus.oDP_rd_nick), 32'd4);
    chk("add_rs1_nick", 32'(bus.oDP_rs1_nick), 32'd3);
    chk("add_rs2_nick", 32'(bus.oDP_rs2_nick), 32'd3);
    chk("add_pc", bus.oDP_pc, 32'h104);
    tick(); #1;
    chk("drain_empty", 32'(bus.oDP_en), 32'd0);

    // ADD x3,x5,x6 stalled on RS full while its rs1 tag 5 is broadcast
    set_iq(1'b1, OP_ADD, 32'h108, 32'd0, 5'd3, 5'd5, 5'd6);
    set_reg(4'd5, 32'h0, 4'd0, 32'h66);
    bus.iRS_full = 1'b1; bus.iROB_nick = 4'd6; #1;
    chk("stall_cap_pop", 32'(bus.oIQ_pop), 32'd1);
    tick();
    set_iq(1'b1, OP_ADD, 32'h10c, 32'd0, 5'd7, 5'd8, 5'd0);
    set_reg(4'd9, 32'h0, 4'd0, 32'h0); #1;
    chk("stall1_dp_en", 32'(bus.oDP_en), 32'd0);
    chk("stall1_pop", 32'(bus.oIQ_pop), 32'd0);
    tick();
    bus.iEX_en = 1'b1; bus.iEX_nick = 4'd5; bus.iEX_dt = 32'h55; #1;
    chk("stall2_dp_en", 32'(bus.oDP_en), 32'd0);
    chk("stall2_pop", 32'(bus.oIQ_pop), 32'd0);
    chk("stall2_byp_nick", 32'(bus.oDP_rs1_nick), 32'd0);
    chk("stall2_byp_dt", bus.oDP_rs1_dt, 32'h55);
    tick();
    bus.iEX_en = 1'b0; #1;
    chk("stall3_pop", 32'(bus.oIQ_pop), 32'd0);
    chk("stall3_snoop_nick", 32'(bus.oDP_rs1_nick), 32'd0);
    chk("stall3_snoop_dt", bus.oDP_rs1_dt, 32'h55);
    tick();
    bus.iRS_full = 1'b0; #1;
    chk("release_dp_en", 32'(bus.oDP_en), 32'd1);
    chk("release_pop", 32'(bus.oIQ_pop), 32'd1);
    chk("release_rd_nick", 32'(bus.oDP_rd_nick), 32'd6);
    chk("release_rs1_dt", bus.oDP_rs1_dt, 32'h55);
    chk("release_rs2_dt", bus.oDP_rs2_dt, 32'h66);
    chk("release_reg_rd", 32'(bus.oREG_rd), 32'd3);
    tick();
    bus.iIQ_en = 1'b0; bus.iROB_nick = 4'd7;
    bus.iEX_en = 1'b1;  bus.iEX_nick = 4'd9;  bus.iEX_dt = 32'hEE;
    bus.iSLB_en = 1'b1; bus.iSLB_nick = 4'd9; bus.iSLB_dt = 32'h99; #1;
    chk("firebyp_dp_en", 32'(bus.oDP_en), 32'd1);
    chk("firebyp_rs1_nick", 32'(bus.oDP_rs1_nick), 32'd0);
    chk("firebyp_ex_wins", bus.oDP_rs1_dt, 32'hEE);
    chk("firebyp_rd_nick", 32'(bus.oDP_rd_nick), 32'd7);
    chk("firebyp_reg_rd", 32'(bus.oREG_rd), 32'd7);
    tick();
    idle();

    // LW x10 routed to SLB, then SW reading x10 picks up LW's new tag
    set_iq(1'b1, OP_LW, 32'h110, 32'h10, 5'd10, 5'd1, 5'd0);
    set_reg(4'd0, 32'h1000, 4'd0, 32'h0);
    bus.iSLB_full = 1'b1; bus.iROB_nick = 4'd8; #1;
    chk("lw_pop", 32'(bus.oIQ_pop), 32'd1);
    tick();
    set_iq(1'b1, OP_SW, 32'h114, 32'h0, 5'd5, 5'd1, 5'd10);
    set_reg(4'd0, 32'h1000, 4'd0, 32'h7); #1;
    chk("lw_slbfull_dp_en", 32'(bus.oDP_en), 32'd0);
    chk("lw_ls", 32'(bus.oDP_ls), 32'd1);
    chk("lw_stall_pop", 32'(bus.oIQ_pop), 32'd0);
    tick();
    bus.iSLB_full = 1'b0; #1;
    chk("lw_dp_en", 32'(bus.oDP_en), 32'd1);
    chk("lw_fire_ls", 32'(bus.oDP_ls), 32'd1);
    chk("lw_rs1_dt", bus.oDP_rs1_dt, 32'h1000);
    chk("lw_reg_rd_en", 32'(bus.oREG_rd_en), 32'd1);
    chk("sw_pop", 32'(bus.oIQ_pop), 32'd1);
    tick();
    bus.iIQ_en = 1'b0; bus.iROB_full = 1'b1; bus.iROB_nick = 4'd9; #1;
    chk("robfull_dp_en", 32'(bus.oDP_en), 32'd0);
    chk("sw_rs2_renamed", 32'(bus.oDP_rs2_nick), 32'd8);
    tick();
    bus.iROB_full = 1'b0; #1;
    chk("sw_dp_en", 32'(bus.oDP_en), 32'd1);
    chk("sw_ls", 32'(bus.oDP_ls), 32'd1);
    chk("sw_no_reg_rd_en", 32'(bus.oREG_rd_en), 32'd0);
    chk("sw_rd_nick", 32'(bus.oDP_rd_nick), 32'd9);
    tick();
    idle();

    // rdy hold, then clr flush while held
    set_iq(1'b1, OP_ADDI, 32'h200, 32'd1, 5'd1, 5'd0, 5'd0);
    tick();
    set_iq(1'b1, OP_ADDI, 32'h204, 32'd2, 5'd2, 5'd0, 5'd0);
    rdy = 1'b0; #1;
    chk("rdy0_dp_en", 32'(bus.oDP_en), 32'd0);
    chk("rdy0_pop", 32'(bus.oIQ_pop), 32'd0);
    tick();
    rdy = 1'b1; bus.iRS_full = 1'b1; clr = 1'b1; #1;
    chk("clr_pop", 32'(bus.oIQ_pop), 32'd0);
    chk("clr_dp_en", 32'(bus.oDP_en), 32'd0);
    tick();
    clr = 1'b0; bus.iRS_full = 1'b0; bus.iIQ_en = 1'b0; #1;
    chk("after_clr_dp_en", 32'(bus.oDP_en), 32'd0);
    chk("after_clr_pc", bus.oDP_pc, 32'h0);
    tick();

    // asynchronous reset in the middle of a stall
    set_iq(1'b1, OP_ADDI, 32'h300, 32'd7, 5'd2, 5'd0, 5'd0);
    tick();
    set_iq(1'b1, OP_ADD, 32'h304, 32'd0, 5'd3, 5'd4, 5'd4);
    bus.iRS_full = 1'b1; #1;
    chk("pre_rst_pc", bus.oDP_pc, 32'h300);
    chk("pre_rst_dp_en", 32'(bus.oDP_en), 32'd0);
    #2; rst = 1'b0; #1;
    chk("midrst_dp_en", 32'(bus.oDP_en), 32'd0);
    chk("midrst_pop", 32'(bus.oIQ_pop), 32'd0);
    chk("midrst_rob_en", 32'(bus.oROB_en), 32'd0);
    chk("midrst_dp_pc", bus.oDP_pc, 32'h0);
    chk("midrst_rob_pc", bus.oROB_pc, 32'h0);
    chk("midrst_imm", bus.oDP_imm, 32'h0);
    chk("midrst_reg_rs1", 32'(bus.oREG_rs1), 32'd0);
    chk("midrst_reg_rd_en", 32'(bus.oREG_rd_en), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
